return_address_stack: RTL

Hardware call/return stack for the RAT MCU program-counter path. It captures the return address (PC_COUNT + 1) when a CALL executes and presents the top entry on FROM_STACK, so the program counter can load it through PC_MUX_SEL = 1 on RET. It sits between the program counter and the control unit, which drives PUSH and POP.

---
 rtl/rat_pkg.sv | 23 ++
 rtl/stack_mem.sv | 38 +++
 rtl/return_address_stack.sv | 119 +++++++++++
 3 files changed

// File: rtl/rat_pkg.sv
// +--------------------------------------------------------------------------+
// | rat_pkg : PC width/type and stack-op encoding shared across the RAT MCU. |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package rat_pkg;

  localparam int PC_WIDTH = 10;

  typedef logic [PC_WIDTH-1:0] pc_addr_t;

  // Encoded as {PUSH, POP} so the strobes cast straight onto the op.
  typedef enum logic [1:0] {
    OP_NONE    = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } stack_op_t;

endpackage

`default_nettype wire

// File: rtl/stack_mem.sv
// +--------------------------------------------------------------------------+
// | stack_mem : DEPTH x ADDR_WIDTH register file, 1 sync write, 1 async read. |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module stack_mem
  import rat_pkg::*;
#(
  parameter int ADDR_WIDTH = PC_WIDTH,
  parameter int DEPTH      = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  logic [ADDR_WIDTH-1:0]      wdata_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output logic [ADDR_WIDTH-1:0]      rdata_o
);

  logic [ADDR_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/return_address_stack.sv
// +--------------------------------------------------------------------------+
// | return_address_stack : CALL/RET return-address stack with sticky errors. |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module return_address_stack
  import rat_pkg::*;
#(
  parameter int ADDR_WIDTH = PC_WIDTH,
  parameter int DEPTH      = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] PC_COUNT,
  input  logic                  PUSH,
  input  logic                  POP,
  input  logic                  CLR_ERR,
  output logic [ADDR_WIDTH-1:0] FROM_STACK,
  output logic                  EMPTY,
  output logic                  FULL,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  ovf_set, unf_set;
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_waddr;
  logic [IDX_W-1:0]      top_idx;
  logic [ADDR_WIDTH-1:0] push_val;
  logic [ADDR_WIDTH-1:0] mem_rdata;
  stack_op_t             op;

  assign op       = stack_op_t'({PUSH, POP});
  assign push_val = PC_COUNT + ADDR_WIDTH'(1);
  // When full, the low bits of count are zero and this wraps to DEPTH-1.
  assign top_idx  = count_q[IDX_W-1:0] - IDX_W'(1);

  assign EMPTY     = (count_q == '0);
  assign FULL      = (count_q == CNT_FULL);
  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = unf_q;

  always_comb begin
    count_d   = count_q;
    mem_we    = 1'b0;
    mem_waddr = count_q[IDX_W-1:0];
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    case (op)
      OP_PUSH: begin
        if (FULL) begin
          ovf_set = 1'b1;
        end else begin
          mem_we  = 1'b1;
          count_d = count_q + CNT_W'(1);
        end
      end
      OP_POP: begin
        if (EMPTY) begin
          unf_set = 1'b1;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      OP_REPLACE: begin
        mem_we = 1'b1;
        if (EMPTY) begin
          // Behaves as a plain push into slot 0, but the pop still faulted.
          count_d = CNT_W'(1);
          unf_set = 1'b1;
        end else begin
          mem_waddr = top_idx;
        end
      end
      default: begin
      end
    endcase
    ovf_d = (ovf_q & ~CLR_ERR) | ovf_set;
    unf_d = (unf_q & ~CLR_ERR) | unf_set;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  stack_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_stack_mem (
    .clk_i   (CLK),
    .rst_ni  (RST),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (push_val),
    .raddr_i (top_idx),
    .rdata_o (mem_rdata)
  );

  assign FROM_STACK = EMPTY ? '0 : mem_rdata;

endmodule

`default_nettype wire
